packet_fifo_reader: RTL and testbench

- Drains complete frames from the synchronous packet FIFO (8-bit data plus EOD marker, 1-cycle registered read latency) and presents them downstream as a valid/ready byte stream with a last flag.
- Sits directly downstream of the packet FIFO and upstream of the MAC TX framer.
- Starts a frame only when at least one whole packet, EOD included, is committed in the FIFO, so the TX side never underruns mid-frame on a slow writer.

---
 rtl/packet_fifo_reader_pkg.sv | 20 ++
 rtl/packet_fifo_reader_skid.sv | 72 +++++++
 rtl/packet_fifo_reader.sv | 145 ++++++++++++++
 tb/tb_packet_fifo_reader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_fifo_reader_pkg.sv
// Shared constants for the packet FIFO reader: state encoding, FIFO word layout
// and the helper that packs a data byte with its EOD marker.
package packet_fifo_reader_pkg;

  localparam int DATA_W  = 8;
  localparam int EOD_BIT = DATA_W;       // EOD sits just above the data byte in a FIFO word
  localparam int WORD_W  = DATA_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  function automatic logic [WORD_W-1:0] pack_word(input logic [DATA_W-1:0] data,
                                                  input logic              eod);
    return {eod, data};
  endfunction

endpackage

// File: rtl/packet_fifo_reader_skid.sv
// Two-entry valid/ready skid buffer holding {last, data} words; the head word
// drives the stream outputs and stays put until it is popped.
module packet_fifo_reader_skid
  import packet_fifo_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] push_word,
  input  logic              pop,
  output logic [1:0]        entries,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid
);

  logic [WORD_W-1:0] head_q, head_d;
  logic [WORD_W-1:0] tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              do_pop;
  logic              do_push;

  assign do_pop  = pop & (cnt_q != 2'd0);
  assign do_push = push & ((cnt_q != 2'd2) | do_pop);

  // NOTE: every combinational output gets its hold value first, so no path can infer a latch.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({do_push, do_pop})
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b10: begin
        if (cnt_q == 2'd0) head_d = push_word;
        else               tail_d = push_word;
        cnt_d = cnt_q + 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = push_word;
        end else begin
          head_d = tail_q;
          tail_d = push_word;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the two storage words are
  // reset as well so out_data reads zero after reset (a real RAM would be left unreset).
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign entries   = cnt_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q[DATA_W-1:0];
  assign out_last  = head_q[EOD_BIT];

endmodule

// File: rtl/packet_fifo_reader.sv
// Drains whole committed frames from the packet FIFO into a valid/ready byte stream.
// Define PACKET_FIFO_READER_IFG_EN to build the inter-frame GAP state (IFG_CYCLES idle cycles).
module packet_fifo_reader
  import packet_fifo_reader_pkg::*;
#(
  parameter int PKT_CNT_W  = 5
`ifdef PACKET_FIFO_READER_IFG_EN
  ,
  parameter int IFG_CYCLES = 12
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_commit,
  input  logic                 fifo_empty,
  output logic                 fifo_re,
  input  logic [DATA_W-1:0]    fifo_do,
  input  logic                 fifo_eod,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [PKT_CNT_W-1:0] pkt_pending,
  output logic                 ovf_err
);

  localparam logic [PKT_CNT_W-1:0] PKT_MAX = '1;
  localparam logic [PKT_CNT_W-1:0] PKT_ONE = PKT_CNT_W'(1);

  state_e               state_q, state_d;
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 inflight_q, inflight_d;
  logic                 eod_seen_q, eod_seen_d;

`ifdef PACKET_FIFO_READER_IFG_EN
  localparam int                 GAP_W    = $clog2(IFG_CYCLES + 1);
  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(IFG_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_ONE  = GAP_W'(1);
  logic [GAP_W-1:0]              gap_cnt_q, gap_cnt_d;
`endif

  logic [1:0] skid_entries;
  logic [1:0] occupancy;
  logic       xfer;
  logic       last_xfer;
  logic       eod_returning;

  assign xfer          = out_valid & out_ready;
  assign last_xfer     = xfer & out_last;
  assign eod_returning = inflight_q & fifo_eod;

  // Credit the byte leaving this cycle so a read can replace it in the same
  // cycle; without that the stream would drop to 2 bytes per 3 cycles.
  assign occupancy = skid_entries + {1'b0, inflight_q} - {1'b0, xfer};

  packet_fifo_reader_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_word (pack_word(fifo_do, fifo_eod)),
    .pop       (out_ready),
    .entries   (skid_entries),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid)
  );

  always_comb begin
    state_d    = state_q;
    eod_seen_d = eod_seen_q;
    fifo_re    = 1'b0;
`ifdef PACKET_FIFO_READER_IFG_EN
    gap_cnt_d  = gap_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pkt_cnt_q != '0) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        eod_seen_d = eod_seen_q | eod_returning;
        fifo_re    = ~fifo_empty & ~eod_seen_q & (occupancy < 2'd2) & ~eod_returning;
        if (last_xfer) begin
          eod_seen_d = 1'b0;
`ifdef PACKET_FIFO_READER_IFG_EN
          state_d    = ST_GAP;
          gap_cnt_d  = '0;
`else
          state_d    = ST_IDLE;
`endif
        end
      end
`ifdef PACKET_FIFO_READER_IFG_EN
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                       gap_cnt_d = gap_cnt_q + GAP_ONE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign inflight_d = fifo_re;

  // A commit and a frame completion in the same cycle cancel out.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    ovf_d     = ovf_q;
    unique case ({pkt_commit, last_xfer})
      2'b10: begin
        if (pkt_cnt_q == PKT_MAX) ovf_d     = 1'b1;
        else                      pkt_cnt_d = pkt_cnt_q + PKT_ONE;
      end
      2'b01:   pkt_cnt_d = pkt_cnt_q - PKT_ONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pkt_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      inflight_q <= 1'b0;
      eod_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_cnt_q  <= pkt_cnt_d;
      ovf_q      <= ovf_d;
      inflight_q <= inflight_d;
      eod_seen_q <= eod_seen_d;
    end
  end

`ifdef PACKET_FIFO_READER_IFG_EN
  always_ff @(posedge clk) begin
    if (rst) gap_cnt_q <= '0;
    else     gap_cnt_q <= gap_cnt_d;
  end
`endif

  assign pkt_pending = pkt_cnt_q;
  assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_packet_fifo_reader.sv
// Directed bench for packet_fifo_reader with a behavioural 1-cycle-latency packet FIFO.
module tb_packet_fifo_reader;

  localparam int PKT_CNT_W = 5;
`ifdef PACKET_FIFO_READER_IFG_EN
  localparam int EXP_GAP = 12 + 3;
`else
  localparam int EXP_GAP = 3;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 pkt_commit = 1'b0;
  logic                 fifo_empty;
  logic                 fifo_re;
  logic [7:0]           fifo_do;
  logic                 fifo_eod;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_last;
  logic                 out_ready = 1'b1;
  logic [PKT_CNT_W-1:0] pkt_pending;
  logic                 ovf_err;

  logic       wr_en = 1'b0;
  logic [8:0] wr_word = '0;
  logic [8:0] fq[$];
  logic [8:0] fw;

  int checks = 0;
  int errors = 0;
  int reads_total = 0;
  int occ = 0;
  int max_occ = 0;

  always #5 clk = ~clk;

  packet_fifo_reader #(.PKT_CNT_W(PKT_CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .pkt_commit  (pkt_commit),
    .fifo_empty  (fifo_empty),
    .fifo_re     (fifo_re),
    .fifo_do     (fifo_do),
    .fifo_eod    (fifo_eod),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .pkt_pending (pkt_pending),
    .ovf_err     (ovf_err)
  );

  // Packet FIFO model: registered read data, registered empty flag.
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fifo_empty <= 1'b1;
      fifo_do    <= '0;
      fifo_eod   <= 1'b0;
    end else begin
      if (fifo_re && fq.size() != 0) begin
        fw = fq.pop_front();
        fifo_do  <= fw[7:0];
        fifo_eod <= fw[8];
      end
      if (wr_en) fq.push_back(wr_word);
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Bytes read but not yet transferred (in flight plus buffered).
  always @(posedge clk) begin
    if (rst) begin
      occ = 0;
    end else begin
      if (fifo_re) reads_total++;
      occ = occ + (fifo_re ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      if (occ > max_occ) max_occ = occ;
      if (out_valid && out_ready && out_last && pkt_pending == '0) begin
        errors++;
        $display("FAIL dec_at_zero: last byte transferred with pkt_pending=%0d, required nonzero", pkt_pending);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic eod, input logic commit);
    wr_en      = 1'b1;
    wr_word    = {eod, d};
    pkt_commit = commit;
    tick();
    wr_en      = 1'b0;
    pkt_commit = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else           tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({out_valid, out_last, fifo_re} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: {valid,last,re}=%b required 000", {out_valid, out_last, fifo_re});
    end
    checks++;
    if (out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: out_data=%h required 00", out_data);
    end
    checks++;
    if ({pkt_pending, ovf_err} !== '0) begin
      errors++;
      $display("FAIL reset_cnt: pending=%0d ovf=%b required 0 0", pkt_pending, ovf_err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_frame;
    logic [7:0] exp_b[4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    bit ok;
    for (int i = 0; i < 4; i++) write_byte(exp_b[i], i == 3, i == 3);
    checks++;
    if (pkt_pending !== 5'd1) begin
      errors++;
      $display("FAIL single_pending_pre: pkt_pending=%0d required 1", pkt_pending);
    end
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_timeout: out_valid=0 after 30 cycles, required 1");
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, out_last, out_data} !== {1'b1, i == 3, exp_b[i]}) begin
        errors++;
        $display("FAIL single_byte%0d: valid=%b last=%b data=%h required 1 %b %h",
                 i, out_valid, out_last, out_data, i == 3, exp_b[i]);
      end
      tick();
    end
    checks++;
    if ({out_valid, pkt_pending} !== {1'b0, 5'd0}) begin
      errors++;
      $display("FAIL single_post: valid=%b pending=%0d required 0 0", out_valid, pkt_pending);
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] exp_w[5] = '{9'h0B1, 9'h0B2, 9'h1B3, 9'h0C1, 9'h1C2};
    logic [8:0] got[$];
    int base, gap, seen_last;
    bit first_last_done;
    base = reads_total;
    write_byte(8'hB1, 1'b0, 1'b0);
    write_byte(8'hB2, 1'b0, 1'b0);
    write_byte(8'hB3, 1'b1, 1'b1);
    write_byte(8'hC1, 1'b0, 1'b0);
    write_byte(8'hC2, 1'b1, 1'b1);
    checks++;
    if (pkt_pending !== 5'd2) begin
      errors++;
      $display("FAIL b2b_pending: pkt_pending=%0d required 2", pkt_pending);
    end
    gap = 0;
    first_last_done = 1'b0;
    seen_last = 0;
    for (int cyc = 0; cyc < 80 && got.size() < 5; cyc++) begin
      if (out_valid && out_ready) begin
        got.push_back({out_last, out_data});
        if (out_last && !first_last_done) begin
          first_last_done = 1'b1;
          checks++;
          if ((reads_total - base) != 3 || fifo_re !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_prefetch: reads=%0d re=%b at first last, required 3 0",
                     reads_total - base, fifo_re);
          end
        end
      end else if (first_last_done && got.size() == 3) begin
        gap++;
      end
      tick();
    end
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL b2b_count: received %0d bytes, required 5", got.size());
    end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL b2b_byte%0d: {last,data}=%h required %h", i, got[i], exp_w[i]);
      end
    end
    checks++;
    if (gap != EXP_GAP) begin
      errors++;
      $display("FAIL b2b_gap: %0d idle cycles between frames, required %0d", gap, EXP_GAP);
    end
  endtask

  task automatic test_stall;
    logic [8:0] got[$];
    logic [9:0] prev_vec;
    bit prev_stalled;
    prev_stalled = 1'b0;
    prev_vec = '0;
    max_occ = 0;
    for (int i = 0; i < 6; i++) write_byte(8'hD0 + 8'(i), i == 5, i == 5);
    for (int cyc = 0; cyc < 100 && got.size() < 6; cyc++) begin
      if (prev_stalled) begin
        checks++;
        if ({out_valid, out_last, out_data} !== prev_vec) begin
          errors++;
          $display("FAIL stall_hold: {valid,last,data}=%h required %h",
                   {out_valid, out_last, out_data}, prev_vec);
        end
      end
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      #1;
      if (out_valid && out_ready) got.push_back({out_last, out_data});
      prev_stalled = out_valid && !out_ready;
      prev_vec = {out_valid, out_last, out_data};
      tick();
    end
    out_ready = 1'b1;
    checks++;
    if (got.size() != 6) begin
      errors++;
      $display("FAIL stall_count: received %0d bytes, required 6", got.size());
    end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== {i == 5, 8'hD0 + 8'(i)}) begin
        errors++;
        $display("FAIL stall_byte%0d: {last,data}=%h required %h", i, got[i], {i == 5, 8'hD0 + 8'(i)});
      end
    end
    checks++;
    if (max_occ > 2) begin
      errors++;
      $display("FAIL stall_occupancy: %0d bytes outstanding, required at most 2", max_occ);
    end
  endtask

  task automatic test_commit_coincident;
    logic [8:0] got[$];
    bit found;
    write_byte(8'hE1, 1'b0, 1'b0);
    write_byte(8'hE2, 1'b1, 1'b1);
    write_byte(8'hF1, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (out_valid && out_last) found = 1'b1;
      else                       tick();
    end
    checks++;
    if (!found || pkt_pending !== 5'd1) begin
      errors++;
      $display("FAIL coinc_pre: found=%b pending=%0d required 1 1", found, pkt_pending);
    end
    write_byte(8'hF2, 1'b1, 1'b1);
    checks++;
    if (pkt_pending !== 5'd1) begin
      errors++;
      $display("FAIL coinc_pending: pkt_pending=%0d required 1", pkt_pending);
    end
    for (int cyc = 0; cyc < 30 && got.size() < 2; cyc++) begin
      if (out_valid && out_ready) got.push_back({out_last, out_data});
      tick();
    end
    checks++;
    if (got.size() != 2 || got[0] !== 9'h0F1 || got[1] !== 9'h1F2) begin
      errors++;
      $display("FAIL coinc_next_frame: got %0d bytes, required F1 then F2(last)", got.size());
    end
    checks++;
    if (pkt_pending !== 5'd0) begin
      errors++;
      $display("FAIL coinc_drain: pkt_pending=%0d required 0", pkt_pending);
    end
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    for (int i = 0; i < 5; i++) write_byte(8'h60 + 8'(i), i == 4, i == 4);
    wait_valid(ok);
    repeat (2) tick();
    checks++;
    if (!ok || out_data !== 8'h62) begin
      errors++;
      $display("FAIL midrst_pre: ok=%b out_data=%h required 1 62", ok, out_data);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({out_valid, fifo_re, pkt_pending} !== '0) begin
      errors++;
      $display("FAIL midrst_clear: valid=%b re=%b pending=%0d required 0 0 0",
               out_valid, fifo_re, pkt_pending);
    end
    rst = 1'b0;
    tick();
    write_byte(8'h7E, 1'b1, 1'b1);
    wait_valid(ok);
    checks++;
    if ({ok, out_last, out_data} !== {1'b1, 1'b1, 8'h7E}) begin
      errors++;
      $display("FAIL midrst_recover: ok=%b last=%b data=%h required 1 1 7e", ok, out_last, out_data);
    end
    tick();
  endtask

  task automatic test_overflow;
    pkt_commit = 1'b1;
    repeat (31) tick();
    pkt_commit = 1'b0;
    checks++;
    if ({pkt_pending, ovf_err} !== {5'd31, 1'b0}) begin
      errors++;
      $display("FAIL ovf_fill: pending=%0d ovf=%b required 31 0", pkt_pending, ovf_err);
    end
    pkt_commit = 1'b1;
    tick();
    pkt_commit = 1'b0;
    checks++;
    if ({pkt_pending, ovf_err} !== {5'd31, 1'b1}) begin
      errors++;
      $display("FAIL ovf_set: pending=%0d ovf=%b required 31 1", pkt_pending, ovf_err);
    end
    repeat (5) tick();
    checks++;
    if (ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%b required 1", ovf_err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({pkt_pending, ovf_err} !== '0) begin
      errors++;
      $display("FAIL ovf_clear: pending=%0d ovf=%b required 0 0", pkt_pending, ovf_err);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_commit_coincident();
    test_reset_mid_frame();
    test_overflow();
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
